// File: rtl/tan_poly.sv
// tan_poly -- iterative Horner evaluator for tan(x) over [0, pi/4].
//
// Maps an unsigned Q1.15 angle (radians) to an unsigned Q0.8 ratio using
//   tan(x) ~= x * (1 + x^2*(C3 + x^2*(C5 + x^2*C7)))
// All products go through one shared 16x16 unsigned multiplier. A small FSM
// steps through one multiply per cycle, so each sample takes six cycles.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   val_i       in   1   input strobe, only sampled while rdy_o=1
//   rdy_o       out  1   high while idle and able to accept a sample
//   tan_poly_i  in  16   unsigned angle, Q1.15 radians
//   val_o       out  1   one-cycle result strobe
//   tan_poly_o  out  8   unsigned tan value, Q0.8; held until the next result

module tan_poly #(
    parameter logic [15:0] C7      = 16'h06E8,  // 17/315, Q1.15
    parameter logic [15:0] C5      = 16'h1111,  // 2/15,   Q1.15
    parameter logic [15:0] C3      = 16'h2AAB,  // 1/3,    Q1.15
    parameter logic [15:0] MAX_ANG = 16'h6488   // pi/4,   Q1.15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        val_i,
    output logic        rdy_o,
    input  logic [15:0] tan_poly_i,
    output logic        val_o,
    output logic [7:0]  tan_poly_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ,
        S_M5,
        S_M3,
        S_M1,
        S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_x;        // clamped angle
    logic [15:0] r_x2;       // x^2, Q1.15
    logic [15:0] r_acc;      // Horner accumulator, Q1.15
    logic        r_val;
    logic [7:0]  r_out;

    logic [15:0] w_x_next;
    logic [15:0] w_x2_next;
    logic [15:0] w_acc_next;
    logic        w_val_next;
    logic [7:0]  w_out_next;

    // Shared multiplier: operands are selected by state.
    logic [15:0] w_mul_a;
    logic [15:0] w_mul_b;
    logic [31:0] w_prod;
    logic [16:0] w_shift;    // product >> 15, truncated
    logic [14:0] w_unused_lsbs;

    always_comb begin
        w_mul_a = r_acc;
        w_mul_b = r_x2;
        case (r_state)
            S_SQ: begin
                w_mul_a = r_x;
                w_mul_b = r_x;
            end
            S_FIN: begin
                w_mul_a = r_acc;
                w_mul_b = r_x;
            end
            default: begin
                w_mul_a = r_acc;
                w_mul_b = r_x2;
            end
        endcase
    end

    assign w_prod        = w_mul_a * w_mul_b;
    assign w_shift       = w_prod[31:15];
    assign w_unused_lsbs = w_prod[14:0];

    // Next-state and datapath updates. With x clamped to pi/4, x^2 and every
    // accumulator value stay below 2^16, so bit 16 of the shifted product is
    // only significant for the final x*acc product.
    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_x2_next    = r_x2;
        w_acc_next   = r_acc;
        w_val_next   = 1'b0;
        w_out_next   = r_out;

        case (r_state)
            S_IDLE: begin
                if (val_i) begin
                    w_x_next     = (tan_poly_i > MAX_ANG) ? MAX_ANG : tan_poly_i;
                    w_state_next = S_SQ;
                end
            end
            S_SQ: begin
                w_x2_next    = w_shift[15:0];
                w_acc_next   = C7;
                w_state_next = S_M5;
            end
            S_M5: begin
                w_acc_next   = C5 + w_shift[15:0];
                w_state_next = S_M3;
            end
            S_M3: begin
                w_acc_next   = C3 + w_shift[15:0];
                w_state_next = S_M1;
            end
            S_M1: begin
                w_acc_next   = 16'h8000 + w_shift[15:0];
                w_state_next = S_FIN;
            end
            S_FIN: begin
                // y >= 1.0 cannot be shown in Q0.8; saturate instead of wrapping.
                w_out_next   = (w_shift >= 17'h08000) ? 8'hFF : w_shift[14:7];
                w_val_next   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_x2    <= '0;
            r_acc   <= '0;
            r_val   <= 1'b0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_x2    <= w_x2_next;
            r_acc   <= w_acc_next;
            r_val   <= w_val_next;
            r_out   <= w_out_next;
        end
    end

    assign rdy_o      = (r_state == S_IDLE);
    assign val_o      = r_val;
    assign tan_poly_o = r_out;

endmodule

// File: tb/tb_tan_poly.sv
// tb_tan_poly -- directed and swept checks of tan_poly.
// Expected results go into a scoreboard queue when a sample is accepted and
// are popped when val_o is seen. The bench tracks acceptance and val_o timing
// with its own busy counter (accept -> five busy cycles -> val_o with rdy_o).

module tb_tan_poly;

    logic        clk;
    logic        rst;
    logic        val_i;
    logic        rdy_o;
    logic [15:0] tan_poly_i;
    logic        val_o;
    logic [7:0]  tan_poly_o;

    tan_poly dut (
        .clk        (clk),
        .rst        (rst),
        .val_i      (val_i),
        .rdy_o      (rdy_o),
        .tan_poly_i (tan_poly_i),
        .val_o      (val_o),
        .tan_poly_o (tan_poly_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec;
    int         n_bad;
    int         busy;        // remaining busy cycles after an accept
    logic       exp_val;     // val_o expected at this sample point
    logic [7:0] sb[$];

    // Reference: Horner evaluation in wide integers, truncating >>15 each step.
    function automatic logic [7:0] model(input logic [15:0] a);
        longint x, x2, acc, y;
        x   = (a > 16'h6488) ? 64'h6488 : longint'(a);
        x2  = (x * x) >> 15;
        acc = 1768;
        acc = 4369  + ((acc * x2) >> 15);
        acc = 10923 + ((acc * x2) >> 15);
        acc = 32768 + ((acc * x2) >> 15);
        y   = (acc * x) >> 15;
        if (y >= 32768) return 8'hFF;
        return 8'((y >> 7) & 255);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: check outputs left by the previous rising edge,
    // drive inputs for the next edge, then advance to the following negedge.
    task automatic step(input logic v, input logic [15:0] a, input logic [7:0] expv);
        logic       accept;
        logic [7:0] e;
        chk("rdy_o", {15'd0, rdy_o}, {15'd0, (busy == 0)});
        chk("val_o", {15'd0, val_o}, {15'd0, exp_val});
        if (val_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $error("FAIL sb_empty: observed val_o=1 expected no result pending");
            end else begin
                e = sb.pop_front();
                chk("tan_poly_o", {8'd0, tan_poly_o}, {8'd0, e});
            end
        end
        val_i      = v;
        tan_poly_i = a;
        accept     = v && (busy == 0);
        if (accept) sb.push_back(expv);
        @(posedge clk);
        exp_val = (busy == 1);
        if (accept) busy = 5;
        else if (busy > 0) busy--;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 8'h00);
    endtask

    initial begin
        logic [15:0] v;
        n_vec = 0; n_bad = 0; busy = 0; exp_val = 1'b0;
        rst = 1'b1; val_i = 1'b1; tan_poly_i = 16'h4000;

        // Reset state, with a strobe present that must be ignored.
        repeat (3) @(negedge clk);
        chk("reset rdy_o", {15'd0, rdy_o}, 16'd1);
        chk("reset val_o", {15'd0, val_o}, 16'd0);
        chk("reset tan_poly_o", {8'd0, tan_poly_o}, 16'h0000);
        rst = 1'b0; val_i = 1'b0;
        @(negedge clk);

        // Nominal 0.5 rad -> 0x8B, then zero, then both clamp cases.
        step(1'b1, 16'h4000, 8'h8B);
        idle(6);
        step(1'b1, 16'h0000, 8'h00);
        idle(6);
        step(1'b1, 16'hFFFF, 8'hFF);
        idle(6);
        step(1'b1, 16'h6488, 8'hFF);
        idle(6);

        // Back-to-back: accept on the edge right after val_o.
        step(1'b1, 16'h4000, 8'h8B);
        idle(5);
        step(1'b1, 16'h0000, 8'h00);
        idle(6);

        // Abort mid-computation: no val_o for this sample, output cleared.
        chk("pre-reset tan_poly_o", {8'd0, tan_poly_o}, 16'h0000);
        step(1'b1, 16'h4000, 8'h8B);
        idle(6);
        chk("pre-abort tan_poly_o", {8'd0, tan_poly_o}, 16'h008B);
        step(1'b1, 16'h3000, 8'h00);
        idle(2);
        rst = 1'b1;
        #1;
        chk("abort rdy_o", {15'd0, rdy_o}, 16'd1);
        chk("abort tan_poly_o", {8'd0, tan_poly_o}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        busy = 0; exp_val = 1'b0;
        idle(8);
        chk("post-abort tan_poly_o", {8'd0, tan_poly_o}, 16'h0000);

        // Busy drop: val_i held high with a new value every cycle.
        for (int i = 0; i < 36; i++) begin
            v = 16'($urandom_range(0, 16'hFFFF));
            step(1'b1, v, model(v));
        end
        idle(7);

        // Sweep across the input range with gaps between samples.
        for (int i = 0; i < 64; i++) begin
            v = 16'(i * 16'h0199 + 16'h0011);
            step(1'b1, v, model(v));
            idle(5 + (i % 3));
        end
        idle(7);

        chk("scoreboard drained", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
